// File: rtl/rv32i_types.sv
// Shared types for the data-cache responder: FSM states and line geometry.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    WB,
    FILL
  } dcache_state_t;

  localparam int unsigned DCACHE_LINE_BITS = 256;
  localparam int unsigned DCACHE_WORDS     = 8;

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/dirty/data storage: asynchronous read by index,
// synchronous byte-enabled line write; valid/dirty cleared by rst.
module dcache_array
  import rv32i_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [S_INDEX-1:0]          index,
  output logic                        valid,
  output logic                        dirty,
  output logic [26-S_INDEX:0]         tag,
  output logic [DCACHE_LINE_BITS-1:0] data,
  input  logic [31:0]                 data_be,
  input  logic [DCACHE_LINE_BITS-1:0] data_in,
  input  logic                        tag_we,
  input  logic [26-S_INDEX:0]         tag_in,
  input  logic                        valid_we,
  input  logic                        valid_in,
  input  logic                        dirty_we,
  input  logic                        dirty_in
);

  localparam int unsigned SETS = 2 ** S_INDEX;

  logic [SETS-1:0]             valid_q;
  logic [SETS-1:0]             dirty_q;
  logic [26-S_INDEX:0]         tag_q  [SETS];
  logic [DCACHE_LINE_BITS-1:0] data_q [SETS];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_we) valid_q[index] <= valid_in;
      if (dirty_we) dirty_q[index] <= dirty_in;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[index] <= tag_in;
    for (int unsigned i = 0; i < 32; i++) begin
      if (data_be[i]) data_q[index][i*8 +: 8] <= data_in[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache answering LSQ requests.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_responder
  import rv32i_types::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [3:0]                  mem_byte_enable,
  input  logic [31:0]                 mem_address,
  input  logic [31:0]                 mem_wdata,
  output logic                        mem_resp,
  output logic [31:0]                 mem_rdata,
  output logic                        pmem_read,
  output logic                        pmem_write,
  output logic [31:0]                 pmem_address,
  output logic [DCACHE_LINE_BITS-1:0] pmem_wdata,
  input  logic [DCACHE_LINE_BITS-1:0] pmem_rdata,
  input  logic                        pmem_resp,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);

  dcache_state_t state, next_state;

  logic [S_INDEX-1:0]          index;
  logic [26-S_INDEX:0]         req_tag;
  logic [2:0]                  word_sel;
  logic                        req, hit;
  logic                        arr_valid, arr_dirty;
  logic [26-S_INDEX:0]         arr_tag;
  logic [DCACHE_LINE_BITS-1:0] arr_data;
  logic [31:0]                 cur_word;
  logic [31:0]                 data_be;
  logic [DCACHE_LINE_BITS-1:0] data_in;
  logic                        tag_we, valid_we, valid_in, dirty_we, dirty_in;
  logic                        rdata_load;
  logic                        unused_addr_bits;

  assign unused_addr_bits = &{1'b0, mem_address[1:0]};

  assign index    = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
  assign req_tag  = mem_address[31:S_INDEX+S_OFFSET];
  assign word_sel = mem_address[4:2];
  assign req      = mem_read | mem_write;
  assign hit      = arr_valid && (arr_tag == req_tag);
  assign cur_word = arr_data[{word_sel, 5'b0} +: 32];

  dcache_array #(.S_INDEX(S_INDEX)) u_array (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .valid    (arr_valid),
    .dirty    (arr_dirty),
    .tag      (arr_tag),
    .data     (arr_data),
    .data_be  (data_be),
    .data_in  (data_in),
    .tag_we   (tag_we),
    .tag_in   (req_tag),
    .valid_we (valid_we),
    .valid_in (valid_in),
    .dirty_we (dirty_we),
    .dirty_in (dirty_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rdata <= '0;
    end else begin
      state <= next_state;
      if (rdata_load) mem_rdata <= cur_word;
    end
  end

  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    data_be      = '0;
    data_in      = '0;
    tag_we       = 1'b0;
    valid_we     = 1'b0;
    valid_in     = 1'b0;
    dirty_we     = 1'b0;
    dirty_in     = 1'b0;
    rdata_load   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // Writes also return the pre-merge word on mem_rdata.
            next_state = RESP;
            rdata_load = 1'b1;
            if (mem_write) begin
              data_be  = {28'b0, mem_byte_enable} << {word_sel, 2'b00};
              data_in  = {DCACHE_WORDS{mem_wdata}};
              dirty_we = 1'b1;
              dirty_in = 1'b1;
            end
          end else if (arr_valid && arr_dirty) begin
            next_state = WB;
          end else begin
            next_state = FILL;
          end
        end
      end
      RESP: begin
        mem_resp   = 1'b1;
        next_state = IDLE;
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {arr_tag, index, 5'b0};
        pmem_wdata   = arr_data;
        if (pmem_resp) begin
          dirty_we   = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, index, 5'b0};
        if (pmem_resp) begin
          data_be    = '1;
          data_in    = pmem_rdata;
          tag_we     = 1'b1;
          valid_we   = 1'b1;
          valid_in   = 1'b1;
          dirty_we   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        after_fill;
  logic [31:0] hit_q, miss_q;

  // The re-lookup right after a fill is the tail of a miss, not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      after_fill <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      after_fill <= (state == FILL) && pmem_resp;
      if (state == IDLE && next_state == RESP && !after_fill && hit_q != '1)
        hit_q <= hit_q + 32'd1;
      if (state == IDLE && (next_state == WB || next_state == FILL) && miss_q != '1)
        miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios plus random
// traffic against a set-level cache model and a line-addressed memory model.
module tb_dcache_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count, miss_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  dcache_responder #(.S_INDEX(3), .S_OFFSET(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  // Reference state: physical memory by line address, and the 8 cache sets.
  logic [255:0] pmem_mem [bit [26:0]];
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [23:0]  m_tag   [8];
  logic [255:0] m_line  [8];
  int unsigned  m_hits, m_misses;
  logic [31:0]  last_rdata;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mem_get(input logic [31:0] a);
    logic [255:0] l;
    if (pmem_mem.exists(a[31:5])) return pmem_mem[a[31:5]];
    for (int j = 0; j < 8; j++)
      l[j*32 +: 32] = ({5'b0, a[31:5]} * 32'h9E3779B1) ^ (j * 32'h01010101);
    return l;
  endfunction

  function automatic logic [31:0] exp_hits();
`ifdef DCACHE_STATS_EN
    return m_hits;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef DCACHE_STATS_EN
    return m_misses;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One request, starting on a negedge with the DUT idle; returns on the
  // negedge after the response cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int unsigned lat, input bit hold);
    logic [2:0]   idx;
    logic [23:0]  tg;
    logic [2:0]   w;
    logic         hit, exp_wb, done, overlap;
    logic [31:0]  wb_addr, fill_addr, exp_rdata, merged;
    logic [255:0] wb_data;
    int unsigned  wcyc, fcyc, n, exp_n;
    idx = addr[7:5];
    tg  = addr[31:8];
    w   = addr[4:2];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb    = !hit && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], idx, 5'b0};
    wb_data   = m_line[idx];
    fill_addr = {tg, idx, 5'b0};
    if (hit) m_hits++; else m_misses++;
    if (exp_wb) pmem_mem[wb_addr[31:5]] = wb_data;
    if (!hit) begin
      m_line[idx]  = mem_get(fill_addr);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    exp_rdata = m_line[idx][w*32 +: 32];
    if (wr) begin
      merged = exp_rdata;
      for (int i = 0; i < 4; i++)
        if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
      m_line[idx][w*32 +: 32] = merged;
      m_dirty[idx] = 1'b1;
    end
    exp_n = hit ? 1 : ((exp_wb ? lat : 0) + lat + 2);

    mem_read = rd; mem_write = wr; mem_byte_enable = be;
    mem_address = addr; mem_wdata = wdata;
    wcyc = 0; fcyc = 0; n = 0; done = 1'b0; overlap = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap = 1'b1;
      if (pmem_write) begin
        wcyc++;
        if (wcyc == 1 && exp_wb) begin
          check("wb_addr", pmem_address, wb_addr);
          check("wb_data", pmem_wdata, wb_data);
        end
        if (wcyc == lat) begin
          if (exp_wb) check("wb_data_held", pmem_wdata, wb_data);
          pmem_resp = 1'b1;
        end
      end else if (pmem_read) begin
        fcyc++;
        if (fcyc == 1) check("fill_addr", pmem_address, fill_addr);
        if (fcyc == lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_get(pmem_address);
        end
      end
      if (mem_resp) begin
        done = 1'b1;
        last_rdata = mem_rdata;
      end
    end
    pmem_resp = 1'b0;
    check("resp_seen", done, 1'b1);
    check("pmem_exclusive", overlap, 1'b0);
    check("wb_cycles", wcyc, exp_wb ? lat : 0);
    check("fill_cycles", fcyc, hit ? 0 : lat);
    check("latency", n, exp_n);
    check("rdata", last_rdata, exp_rdata);
    if (!hold) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
    @(negedge clk);
    check("single_resp", mem_resp, 1'b0);
    check("hit_count", hit_count, exp_hits());
    check("miss_count", miss_count, exp_misses());
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    int unsigned  n;
    int unsigned  op;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
    mem_address = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_pmem_wdata", pmem_wdata, 256'h0);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cold read miss; fill line word1 = DEADBEEF
    l = mem_get(32'h0000_1000);
    l[63:32] = 32'hDEADBEEF;
    pmem_mem[27'h80] = l;
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_1004, 32'h0, 2, 1'b0);
    check("cold_read_value", last_rdata, 32'hDEADBEEF);

    // Byte store then read-back
    do_req(1'b0, 1'b1, 4'b0010, 32'h0000_1004, 32'h0000_AA00, 1, 1'b0);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_1004, 32'h0, 1, 1'b0);
    check("store_merge_value", last_rdata, 32'hDEADAAEF);

    // Dirty eviction by a conflicting tag in the same set
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_1104, 32'h0, 3, 1'b0);
    check("evicted_word1", pmem_mem[27'h80][63:32], 32'hDEADAAEF);

    // Back-to-back hits with the request held across mem_resp
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 1'b0, 4'h0, 32'h0000_1100 + i * 4, 32'h0, 1, 1'b1);
    do_req(1'b0, 1'b1, 4'hF, 32'h0000_1110, 32'hCAFE_F00D, 1, 1'b1);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_1110, 32'h0, 1, 1'b0);

    // Reset during FILL, then a stray pmem_resp
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h0000_2040;
    n = 0;
    while (!(pmem_read || pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_fill_reached", pmem_read, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("abort_pmem_read", pmem_read, 1'b0);
    check("abort_pmem_write", pmem_write, 1'b0);
    check("abort_mem_resp", mem_resp, 1'b0);
    check("abort_hit_count", hit_count, 32'h0);
    check("abort_miss_count", miss_count, 32'h0);
    rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("stray_pmem_read", pmem_read, 1'b0);
    check("stray_mem_resp", mem_resp, 1'b0);
    @(negedge clk);
    check("stray_idle_read", pmem_read, 1'b0);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_2040, 32'h0, 2, 1'b0);

    // Read and write together count as a write
    do_req(1'b1, 1'b1, 4'hF, 32'h0000_3008, 32'h1234_5678, 2, 1'b0);
    do_req(1'b1, 1'b0, 4'h0, 32'h0000_3008, 32'h0, 1, 1'b0);
    check("rw_both_value", last_rdata, 32'h1234_5678);

    // Random traffic over a few conflicting tags per set
    for (int t = 0; t < 80; t++) begin
      a  = {22'h0, 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 2'b00};
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, 4'($urandom), a, $urandom,
             $urandom_range(1, 4), bit'($urandom_range(0, 1)));
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
